neuron_update_scheduler: RTL and testbench

NEURON_UPDATE_SCHEDULER -- requirements
Module: neuron_update_scheduler

---
 rtl/neuron_update_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_neuron_update_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_update_scheduler.sv
// Neuron update scheduler: walks NUM_NEURONS virtual neurons through one shared
// update datapath per timestep, stores the new v/u state and collects spike flags.
//
// Datapath handshake: a request transfers on any cycle where dp_req and dp_ready
// are both high; until then dp_req stays high and dp_sel/dp_v/dp_u/dp_i do not
// change. After a transfer dp_req drops and exactly one result is awaited;
// dp_rvalid is looked at only while waiting for that result.
module neuron_update_scheduler #(
    parameter int NUM_NEURONS = 4,
    parameter int WIDTH       = 18,
    parameter int TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   step_start,
    output logic                   busy,
    output logic                   step_done,
    output logic [NUM_NEURONS-1:0] spike_vec,
    output logic                   err_timeout,
    output logic [7:0]             overrun_cnt,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_idx,
    input  logic [2:0]             cfg_sel,
    input  logic [WIDTH-1:0]       cfg_i,
    output logic                   dp_req,
    input  logic                   dp_ready,
    output logic [2:0]             dp_sel,
    output logic [WIDTH-1:0]       dp_v,
    output logic [WIDTH-1:0]       dp_u,
    output logic [WIDTH-1:0]       dp_i,
    input  logic                   dp_rvalid,
    input  logic [WIDTH-1:0]       dp_v_new,
    input  logic [WIDTH-1:0]       dp_u_new,
    input  logic                   dp_spike,
    output logic [2:0]             dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0]       LAST_IDX = 3'(NUM_NEURONS - 1);
    localparam int               TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT - 1);
    // Resting membrane potential -65 and recovery 8 in signed 8.9 fixed point.
    localparam logic [WIDTH-1:0] V_RESET  = WIDTH'(-65 * 512);
    localparam logic [WIDTH-1:0] U_RESET  = WIDTH'(8 * 512);

    logic [2:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [TW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] v_q   [NUM_NEURONS];
    logic [WIDTH-1:0] u_q   [NUM_NEURONS];
    logic [WIDTH-1:0] i_q   [NUM_NEURONS];
    logic [2:0]       sel_q [NUM_NEURONS];

    logic [2:0]       pay_sel_q, pay_sel_d;
    logic [WIDTH-1:0] pay_v_q, pay_v_d;
    logic [WIDTH-1:0] pay_u_q, pay_u_d;
    logic [WIDTH-1:0] pay_i_q, pay_i_d;

    logic [NUM_NEURONS-1:0] pend_q;
    logic [NUM_NEURONS-1:0] spike_q;
    logic                   done_q;
    logic                   err_q;
    logic [7:0]             ovr_q;

    logic accept;
    logic timeout_hit;
    logic load_payload;

    // A result counts only while waiting; one arriving on the last allowed cycle still wins.
    assign accept       = (state_q == S_WAIT) && dp_rvalid;
    assign timeout_hit  = (state_q == S_WAIT) && !dp_rvalid && (cnt_q == TO_LAST);
    assign load_payload = (state_d == S_ISSUE) && (state_q != S_ISSUE);

    assign busy        = (state_q != S_IDLE);
    assign dp_req      = (state_q == S_ISSUE);
    assign dp_sel      = pay_sel_q;
    assign dp_v        = pay_v_q;
    assign dp_u        = pay_u_q;
    assign dp_i        = pay_i_q;
    assign step_done   = done_q;
    assign spike_vec   = spike_q;
    assign err_timeout = err_q;
    assign overrun_cnt = ovr_q;
    assign dbg_state   = state_q;

    // Next state, neuron index and wait counter for the pass sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (step_start) begin
                    state_d = S_ISSUE;
                    idx_d   = 3'd0;
                end
            end
            S_ISSUE: begin
                if (dp_ready) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (accept || timeout_hit) begin
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                idx_d   = 3'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Payload snapshot of the neuron about to be issued, taken on ISSUE entry.
    always_comb begin
        pay_sel_d = pay_sel_q;
        pay_v_d   = pay_v_q;
        pay_u_d   = pay_u_q;
        pay_i_d   = pay_i_q;
        if (load_payload) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if (idx_d == 3'(k)) begin
                    pay_sel_d = sel_q[k];
                    pay_v_d   = v_q[k];
                    pay_u_d   = u_q[k];
                    pay_i_d   = i_q[k];
                end
            end
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Per-neuron state: config writes land in sel/i, datapath results in v/u.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                v_q[k]   <= V_RESET;
                u_q[k]   <= U_RESET;
                i_q[k]   <= '0;
                sel_q[k] <= 3'd0;
            end
        end else begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if (cfg_we && (cfg_idx == 3'(k))) begin
                    sel_q[k] <= cfg_sel;
                    i_q[k]   <= cfg_i;
                end
                if (accept && (idx_q == 3'(k))) begin
                    v_q[k] <= dp_v_new;
                    u_q[k] <= dp_u_new;
                end
            end
        end
    end

    // Issued payload registers, so late config writes cannot disturb a presented request.
    always_ff @(posedge clk) begin
        if (rst) begin
            pay_sel_q <= 3'd0;
            pay_v_q   <= '0;
            pay_u_q   <= '0;
            pay_i_q   <= '0;
        end else begin
            pay_sel_q <= pay_sel_d;
            pay_v_q   <= pay_v_d;
            pay_u_q   <= pay_u_d;
            pay_i_q   <= pay_i_d;
        end
    end

    // Pending spikes, published spike vector, completion pulse, error and overrun status.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            spike_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 8'd0;
        end else begin
            done_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                spike_q <= pend_q;
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
            if (step_start && busy && (ovr_q != 8'hFF)) begin
                ovr_q <= ovr_q + 8'd1;
            end
            for (int k = 0; k < NUM_NEURONS; k++) begin
                if ((accept || timeout_hit) && (idx_q == 3'(k))) begin
                    pend_q[k] <= accept & dp_spike;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Bench for neuron_update_scheduler: a pass driver that also plays the datapath,
// a reference model of the neuron registers, and a monitor that checks every
// presented request payload and every step_done against queued expectations.
module tb_neuron_update_scheduler;

    localparam int N     = 4;
    localparam int WIDTH = 18;
    localparam int TO    = 15;
    localparam int PW    = 3 + 3 * WIDTH;
    localparam logic [WIDTH-1:0] V0 = 18'h37E00;
    localparam logic [WIDTH-1:0] U0 = 18'h01000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT ----------------
    logic             step_start = 1'b0;
    logic             busy;
    logic             step_done;
    logic [N-1:0]     spike_vec;
    logic             err_timeout;
    logic [7:0]       overrun_cnt;
    logic             cfg_we = 1'b0;
    logic [2:0]       cfg_idx = 3'd0;
    logic [2:0]       cfg_sel = 3'd0;
    logic [WIDTH-1:0] cfg_i = '0;
    logic             dp_req;
    logic             dp_ready = 1'b0;
    logic [2:0]       dp_sel;
    logic [WIDTH-1:0] dp_v, dp_u, dp_i;
    logic             dp_rvalid = 1'b0;
    logic [WIDTH-1:0] dp_v_new = '0;
    logic [WIDTH-1:0] dp_u_new = '0;
    logic             dp_spike = 1'b0;
    logic [2:0]       dbg_state;

    neuron_update_scheduler #(.NUM_NEURONS(N), .WIDTH(WIDTH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .step_start(step_start), .busy(busy),
        .step_done(step_done), .spike_vec(spike_vec), .err_timeout(err_timeout),
        .overrun_cnt(overrun_cnt), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_sel(cfg_sel), .cfg_i(cfg_i), .dp_req(dp_req), .dp_ready(dp_ready),
        .dp_sel(dp_sel), .dp_v(dp_v), .dp_u(dp_u), .dp_i(dp_i),
        .dp_rvalid(dp_rvalid), .dp_v_new(dp_v_new), .dp_u_new(dp_u_new),
        .dp_spike(dp_spike), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [PW-1:0] exp_q[$];
    int            done_cyc_q[$];
    logic [N-1:0]  done_spk_q[$];

    // Reference model of the neuron registers and status.
    logic [WIDTH-1:0] mv [N];
    logic [WIDTH-1:0] mu [N];
    logic [WIDTH-1:0] mi [N];
    logic [2:0]       msel [N];
    logic             m_err;
    int               m_ovr;
    logic [N-1:0]     m_spk;

    // Per-neuron plan for the next pass (how the bench datapath behaves).
    int               p_rdy [N];   // cycles dp_ready is held low in ISSUE
    int               p_rsp [N];   // result delay in WAIT, -1 = never answer
    logic [WIDTH-1:0] p_v [N];
    logic [WIDTH-1:0] p_u [N];
    logic             p_spk [N];
    logic             p_cfg [N];   // config write to this neuron while it is presented
    logic [2:0]       p_csel [N];
    logic [WIDTH-1:0] p_ci [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string detail);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (dp_req) begin
                if (exp_q.size() == 0) begin
                    flag("dp_req_unexpected", "dp_req=1, required no request");
                end else begin
                    check("dp_payload", {dp_sel, dp_v, dp_u, dp_i}, exp_q[0]);
                    if (dp_ready) void'(exp_q.pop_front());
                end
            end
            if (step_done) begin
                if (done_cyc_q.size() == 0) begin
                    flag("step_done_unexpected", "step_done=1, required 0");
                end else begin
                    check("spike_vec_at_done", spike_vec, done_spk_q.pop_front());
                    check("done_cycle", cyc, done_cyc_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int n = 0; n < N; n++) begin
            mv[n] = V0; mu[n] = U0; mi[n] = '0; msel[n] = 3'd0;
        end
        m_err = 1'b0;
        m_ovr = 0;
        m_spk = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [2:0] sel, input logic [WIDTH-1:0] val);
        cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_i = val;
        tick();
        cfg_we = 1'b0;
        if (int'(idx) < N) begin
            msel[idx] = sel;
            mi[idx]   = val;
        end
    endtask

    task automatic plan_loop();
        for (int n = 0; n < N; n++) begin
            p_rdy[n] = 0; p_rsp[n] = 0; p_v[n] = mv[n]; p_u[n] = mu[n];
            p_spk[n] = 1'b0; p_cfg[n] = 1'b0; p_csel[n] = 3'd0; p_ci[n] = '0;
        end
    endtask

    task automatic plan_random();
        int r;
        for (int n = 0; n < N; n++) begin
            p_rdy[n] = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 9));
            p_rsp[n] = (r == 0) ? -1 : (r == 1) ? TO - 1 : int'($urandom_range(0, 3));
            p_v[n] = WIDTH'($urandom);
            p_u[n] = WIDTH'($urandom);
            p_spk[n] = 1'($urandom_range(0, 1));
            p_cfg[n] = ($urandom_range(0, 3) == 0) && (p_rdy[n] > 0);
            p_csel[n] = 3'($urandom_range(0, 7));
            p_ci[n] = WIDTH'($urandom);
        end
    endtask

    // Plays the datapath for neuron n following its plan.
    task automatic serve(input int n);
        int guard = 0;
        while (!dp_req && guard < 50) begin
            tick();
            guard++;
        end
        if (!dp_req) begin
            flag("dp_req_wait", $sformatf("no request for neuron %0d within 50 cycles", n));
            return;
        end
        for (int k = 0; k < p_rdy[n]; k++) begin
            // stray results while not waiting must be ignored
            dp_ready = 1'b0;
            dp_rvalid = 1'b1; dp_v_new = WIDTH'($urandom); dp_u_new = WIDTH'($urandom); dp_spike = 1'b1;
            if (p_cfg[n] && k == 0) begin
                cfg_we = 1'b1; cfg_idx = 3'(n); cfg_sel = p_csel[n]; cfg_i = p_ci[n];
            end
            tick();
            cfg_we = 1'b0;
        end
        dp_rvalid = 1'b0;
        dp_ready = 1'b1;
        tick();
        dp_ready = 1'b0;
        if (p_rsp[n] >= 0) begin
            repeat (p_rsp[n]) tick();
            dp_rvalid = 1'b1; dp_v_new = p_v[n]; dp_u_new = p_u[n]; dp_spike = p_spk[n];
            tick();
            dp_rvalid = 1'b0;
        end else begin
            repeat (TO) tick();
            // late answer after the timeout: must be ignored
            dp_rvalid = 1'b1; dp_v_new = WIDTH'($urandom); dp_u_new = WIDTH'($urandom); dp_spike = 1'b1;
            tick();
            dp_rvalid = 1'b0;
        end
    endtask

    // One full pass; hold=1 keeps step_start high for the whole pass.
    task automatic run_pass(input bit hold);
        int lat = 2;
        int guard = 0;
        logic [N-1:0] spk;
        for (int n = 0; n < N; n++) begin
            exp_q.push_back({msel[n], mv[n], mu[n], mi[n]});
            lat += (p_rdy[n] + 1) + ((p_rsp[n] >= 0) ? p_rsp[n] + 1 : TO) + 1;
        end
        for (int n = 0; n < N; n++) begin
            if (p_rsp[n] >= 0) begin
                mv[n] = p_v[n]; mu[n] = p_u[n]; spk[n] = p_spk[n];
            end else begin
                m_err = 1'b1; spk[n] = 1'b0;
            end
            if (p_cfg[n]) begin
                msel[n] = p_csel[n]; mi[n] = p_ci[n];
            end
        end
        done_spk_q.push_back(spk);
        done_cyc_q.push_back(cyc + lat);
        step_start = 1'b1;
        tick();
        if (!hold) step_start = 1'b0;
        check("busy_after_start", busy, 1);
        check("spike_vec_held", spike_vec, m_spk);
        for (int n = 0; n < N; n++) serve(n);
        while (!step_done && guard < 40) begin
            tick();
            guard++;
        end
        step_start = 1'b0;
        if (!step_done) flag("step_done_wait", "step_done=0 after 40 cycles, required 1");
        if (hold) m_ovr = (m_ovr + lat - 1 > 255) ? 255 : m_ovr + lat - 1;
        m_spk = spk;
        check("busy_at_done", busy, 0);
        check("err_timeout", err_timeout, m_err);
        check("overrun_cnt", overrun_cnt, m_ovr);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_step_done", step_done, 0);
        check("rst_dp_req", dp_req, 0);
        check("rst_spike_vec", spike_vec, 0);
        check("rst_err", err_timeout, 0);
        check("rst_overrun", overrun_cnt, 0);

        // readback of reset state through a loopback datapath
        plan_loop();
        run_pass(0);

        // spike only from neuron 2
        plan_loop();
        p_spk[2] = 1'b1;
        run_pass(0);

        // neuron 1 stalled 5 cycles with a config write to it while presented
        plan_loop();
        p_rdy[1] = 5; p_cfg[1] = 1'b1; p_csel[1] = 3'd5; p_ci[1] = 18'h00A00;
        run_pass(0);

        // neuron 3 never answers
        plan_loop();
        p_rsp[3] = -1;
        run_pass(0);

        // result arrives on the very cycle the timeout expires
        plan_loop();
        p_rsp[0] = TO - 1; p_v[0] = 18'h12345; p_u[0] = 18'h00321; p_spk[0] = 1'b1;
        run_pass(0);

        // config writes between passes, including out-of-range indices
        for (int k = 0; k < 8; k++) cfg_write(3'(k), 3'($urandom_range(0, 7)), WIDTH'($urandom));

        repeat (20) begin
            plan_random();
            run_pass(0);
            if ($urandom_range(0, 2) == 0) cfg_write(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), WIDTH'($urandom));
        end

        // overrun saturation: step_start held high through many passes
        repeat (24) begin
            plan_random();
            run_pass(1);
        end

        // reset in the middle of a pass
        plan_loop();
        p_rdy[1] = 3;
        for (int n = 0; n < N; n++) exp_q.push_back({msel[n], mv[n], mu[n], mi[n]});
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        dp_ready = 1'b1;
        tick();
        dp_ready = 1'b0;
        dp_rvalid = 1'b1; dp_v_new = mv[0]; dp_u_new = mu[0]; dp_spike = 1'b1;
        tick();
        dp_rvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        done_cyc_q.delete();
        done_spk_q.delete();
        model_reset();
        check("midrst_busy", busy, 0);
        check("midrst_step_done", step_done, 0);
        check("midrst_dp_req", dp_req, 0);
        check("midrst_spike_vec", spike_vec, 0);
        check("midrst_err", err_timeout, 0);
        check("midrst_overrun", overrun_cnt, 0);
        repeat (20) tick();

        // state after reset must be back at the reset values
        plan_loop();
        run_pass(0);

        check("exp_q_left", exp_q.size(), 0);
        check("done_q_left", done_cyc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at 2000000, required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
